// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide execution unit.
//  - M-extension funct3 codes and the OP opcode / funct7 select constant
//  - default data and ROB tag widths used by the surrounding core
//  - divider FSM state encoding
//  - small decode helpers for funct3
package muldiv_unit_pkg;

    localparam int DATA_WID = 32;
    localparam int ROB_WID  = 4;

    localparam logic [6:0] OPCODE_CAL  = 7'b0110011;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [2:0] {
        FUNCT3_MUL    = 3'b000,
        FUNCT3_MULH   = 3'b001,
        FUNCT3_MULHSU = 3'b010,
        FUNCT3_MULHU  = 3'b011,
        FUNCT3_DIV    = 3'b100,
        FUNCT3_DIVU   = 3'b101,
        FUNCT3_REM    = 3'b110,
        FUNCT3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;

    // funct3[2] separates the divide class from the multiply class.
    function automatic logic is_div_op(input logic [2:0] f);
        return f[2];
    endfunction

    // rs1 is sign-extended for MULH and MULHSU, rs2 only for MULH.
    function automatic logic rs1_signed(input logic [2:0] f);
        return (f == FUNCT3_MULH) || (f == FUNCT3_MULHSU);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f);
        return (f == FUNCT3_MULH);
    endfunction

endpackage

// File: rtl/muldiv_unit_div.sv
// Iterative restoring radix-2 divider.
//  IDLE -> CALC (XLEN cycles, one quotient bit each) -> FIX (signs) -> IDLE.
//  Divide-by-zero and signed overflow finish in the start cycle without
//  leaving IDLE. done/result are combinational; the caller registers them.
// Ports:
//  clk, rst     clock, synchronous active-high reset
//  en           global enable; low freezes all state
//  flush        abandon any divide in progress
//  start        begin a divide (only honoured in IDLE)
//  is_signed    DIV/REM when high, DIVU/REMU when low
//  want_rem     return remainder instead of quotient
//  dividend     rs1
//  divisor      rs2
//  busy         FSM is not IDLE
//  done         result valid this cycle
//  result       quotient or remainder
module div_iter
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            flush,
    input  logic            start,
    input  logic            is_signed,
    input  logic            want_rem,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    div_state_e state_q, state_d;

    logic [XLEN-1:0]  quo_q, rem_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q, neg_rem_q, want_rem_q;

    logic             a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic             div_zero, overflow, special;
    logic [XLEN-1:0]  special_res;
    logic [XLEN:0]    trial;
    logic             take;

    assign a_neg = is_signed & dividend[XLEN-1];
    assign b_neg = is_signed & divisor[XLEN-1];
    // -(-2^(XLEN-1)) wraps to the same bits, which read unsigned is the
    // correct magnitude, so the most negative dividend needs no special case.
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor  : divisor;

    assign div_zero = (divisor == '0);
    assign overflow = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                      && (divisor == '1);
    assign special  = div_zero | overflow;

    always_comb begin
        if (div_zero) special_res = want_rem ? dividend : '1;
        else          special_res = want_rem ? '0 : dividend;
    end

    // Partial remainder shifted left with the next dividend bit, minus the
    // divisor; a clear sign bit means the subtraction fits.
    assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    assign take  = ~trial[XLEN];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst || flush) state_q <= DIV_IDLE;
        else if (en)      state_q <= state_d;
    end

    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: if (start && !special) state_d = DIV_CALC;
            DIV_CALC: if (cnt_q == '0)       state_d = DIV_FIX;
            DIV_FIX:                         state_d = DIV_IDLE;
            default:                         state_d = DIV_IDLE;
        endcase
    end

    // NOTE: the datapath carries no reset; it is always loaded on start
    // before being read, and only the FSM state must come up known.
    always_ff @(posedge clk) begin
        if (en) begin
            if (state_q == DIV_IDLE && start) begin
                quo_q      <= a_mag;
                rem_q      <= '0;
                dvs_q      <= b_mag;
                cnt_q      <= CNT_W'(XLEN - 1);
                neg_quo_q  <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                want_rem_q <= want_rem;
            end else if (state_q == DIV_CALC) begin
                rem_q <= take ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                quo_q <= {quo_q[XLEN-2:0], take};
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign busy = (state_q != DIV_IDLE);

    always_comb begin
        done   = 1'b0;
        result = '0;
        if (state_q == DIV_FIX) begin
            done = 1'b1;
            if (want_rem_q) result = neg_rem_q ? -rem_q : rem_q;
            else            result = neg_quo_q ? -quo_q : quo_q;
        end else if (state_q == DIV_IDLE && start && special) begin
            done   = 1'b1;
            result = special_res;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execution unit: pipelined multiplier plus iterative divider,
// sharing one registered CDB result port.
// Ports:
//  clk, rst      clock, synchronous active-high reset
//  rdy           global enable; low holds every register
//  rollback      flush all in-flight ops
//  md_en         issue strobe
//  funct3        M-extension op code
//  val1, val2    rs1 / rs2 operands
//  rob_pos       destination ROB tag
//  md_ready      combinational: funct3 on the port can be accepted now
//  res_done      one-cycle result strobe
//  res_rob_pos   result tag (holds when res_done is low)
//  res_cal       result value (holds when res_done is low)
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 3,
    parameter int ROB_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             md_en,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  val1,
    input  logic [XLEN-1:0]  val2,
    input  logic [ROB_W-1:0] rob_pos,
    output logic             md_ready,
    output logic             res_done,
    output logic [ROB_W-1:0] res_rob_pos,
    output logic [XLEN-1:0]  res_cal
);

    // The output register is the last multiplier stage, so the internal
    // shift register is one shorter than the latency (kept >=1 entry).
    localparam int PIPE_D = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;

    typedef struct packed {
        logic             valid;
        logic [ROB_W-1:0] tag;
        logic             hi;
        logic [2*XLEN-1:0] prod;
    } mul_stage_t;

    mul_stage_t      mul_in, mul_out;
    mul_stage_t      pipe_q [PIPE_D];
    logic            mul_busy;
    logic            accept, mul_accept, div_accept;
    logic            div_busy, div_done;
    logic [XLEN-1:0] div_result;
    logic [ROB_W-1:0] div_tag_q, div_tag;
    logic [2*XLEN-1:0] a_w, b_w;

    // A DIV may only start once the multiplier is empty, and nothing starts
    // while a divide is running, so the two paths never finish together.
    assign md_ready   = !div_busy && (!is_div_op(funct3) || !mul_busy);
    assign accept     = md_en && md_ready && rdy && !rollback && !rst;
    assign mul_accept = accept && !is_div_op(funct3);
    assign div_accept = accept &&  is_div_op(funct3);

    // Extending straight to 2*XLEN gives the same low 2*XLEN product bits as
    // an (XLEN+1)-bit signed multiply, with no width mismatch.
    assign a_w = {{XLEN{rs1_signed(funct3) & val1[XLEN-1]}}, val1};
    assign b_w = {{XLEN{rs2_signed(funct3) & val2[XLEN-1]}}, val2};

    always_comb begin
        mul_in.valid = mul_accept;
        mul_in.tag   = rob_pos;
        mul_in.hi    = (funct3 != FUNCT3_MUL);
        mul_in.prod  = a_w * b_w;
    end

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            for (int i = 0; i < PIPE_D; i++) pipe_q[i].valid <= 1'b0;
        end else if (rdy) begin
            pipe_q[0] <= mul_in;
            for (int i = 1; i < PIPE_D; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    always_comb begin
        mul_busy = 1'b0;
        for (int i = 0; i < PIPE_D; i++) mul_busy = mul_busy | pipe_q[i].valid;
        mul_busy = mul_busy && (MUL_STAGES > 1);
    end

    always_comb begin
        if (MUL_STAGES == 1) mul_out = mul_in;
        else                 mul_out = pipe_q[PIPE_D-1];
    end

    div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .flush     (rollback),
        .start     (div_accept),
        .is_signed (!funct3[0]),
        .want_rem  (funct3[1]),
        .dividend  (val1),
        .divisor   (val2),
        .busy      (div_busy),
        .done      (div_done),
        .result    (div_result)
    );

    always_ff @(posedge clk) begin
        if (rdy && div_accept) div_tag_q <= rob_pos;
    end

    // Fast-path results complete in the accept cycle, before the tag is stored.
    assign div_tag = div_busy ? div_tag_q : rob_pos;

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            res_done    <= 1'b0;
            res_rob_pos <= '0;
            res_cal     <= '0;
        end else if (rdy) begin
            res_done <= mul_out.valid | div_done;
            if (mul_out.valid) begin
                res_rob_pos <= mul_out.tag;
                res_cal     <= mul_out.hi ? mul_out.prod[2*XLEN-1:XLEN]
                                          : mul_out.prod[XLEN-1:0];
            end else if (div_done) begin
                res_rob_pos <= div_tag;
                res_cal     <= div_result;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32, MUL_STAGES=3, ROB_W=4).
// Expected results and completion cycles go into a scoreboard queue at
// issue; a negedge monitor pops and compares whenever res_done is high.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT_MUL = 3;
    localparam int LAT_DIV = XLEN + 2;

    logic            clk, rst, rdy, rollback, md_en;
    logic [2:0]      funct3;
    logic [XLEN-1:0] val1, val2;
    logic [3:0]      rob_pos;
    logic            md_ready, res_done;
    logic [3:0]      res_rob_pos;
    logic [XLEN-1:0] res_cal;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
        int          due;
    } sb_t;

    sb_t sb[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_err = 0;

    muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(3), .ROB_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .rollback    (rollback),
        .md_en       (md_en),
        .funct3      (funct3),
        .val1        (val1),
        .val2        (val2),
        .rob_pos     (rob_pos),
        .md_ready    (md_ready),
        .res_done    (res_done),
        .res_rob_pos (res_rob_pos),
        .res_cal     (res_cal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model written from the ISA definition.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int ia, ib;
        ia = a;
        ib = b;
        case (f)
            3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); return p[31:0]; end
            3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
            3'd2: begin p = longint'($signed(a)) * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF :
                         (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a :
                         (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return LAT_MUL;
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return LAT_DIV;
    endfunction

    // Present an op, wait (bounded) for md_ready, and log the expectation.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] exp, output int acc);
        int w;
        sb_t e;
        md_en = 1'b1; funct3 = f; val1 = a; val2 = b; rob_pos = tag;
        w = 0;
        @(negedge clk);
        while (!md_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        acc = cyc;
        if (!md_ready) begin
            check("issue_timeout", 64'(md_ready), 64'd1);
        end else begin
            e.tag = tag; e.val = exp; e.due = cyc + latency(f, a, b);
            sb.push_back(e);
        end
        @(posedge clk);
        #1 md_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && res_done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(res_done), 64'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("res_tag",   64'(res_rob_pos), 64'(e.tag));
                check("res_val",   64'(res_cal),     64'(e.val));
                check("res_cycle", 64'(cyc),         64'(e.due));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc, acc2;
        logic [2:0] f;
        logic [31:0] a, b;

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; md_en = 1'b0;
        funct3 = 3'd0; val1 = '0; val2 = '0; rob_pos = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_done",  64'(res_done),    64'd0);
        check("rst_tag",   64'(res_rob_pos), 64'd0);
        check("rst_cal",   64'(res_cal),     64'd0);
        check("rst_ready", 64'(md_ready),    64'd1);
        @(posedge clk); #1;

        // Back-to-back multiplies: results at +3 and +4 of the first accept.
        issue(FUNCT3_MUL,  32'd7,         32'hFFFF_FFFD, 4'd1, 32'hFFFF_FFEB, acc);
        issue(FUNCT3_MULH, 32'h8000_0000, 32'h8000_0000, 4'd2, 32'h4000_0000, acc2);
        check("mul_b2b", 64'(acc2), 64'(acc + 1));
        issue(FUNCT3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 32'hFFFF_FFFF, acc);
        issue(FUNCT3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 32'hFFFF_FFFE, acc);

        // Signed divide: busy throughout, result 34 cycles after accept.
        issue(FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 4'd5, 32'hFFFF_FFFD, acc);
        funct3 = FUNCT3_MUL;
        @(negedge clk);
        check("div_busy_early", 64'(md_ready), 64'd0);
        repeat (32) @(negedge clk);
        check("div_busy_fix",   64'(md_ready), 64'd0);
        @(negedge clk);
        check("div_ready_back", 64'(md_ready), 64'd1);
        @(posedge clk); #1;
        issue(FUNCT3_REM, 32'hFFFF_FFF9, 32'd2, 4'd6, 32'hFFFF_FFFF, acc);

        // Fast-path special cases, one cycle each, back to back.
        issue(FUNCT3_DIVU, 32'd5,         32'd0,         4'd7, 32'hFFFF_FFFF, acc);
        issue(FUNCT3_REM,  32'd5,         32'd0,         4'd8, 32'd5,         acc);
        issue(FUNCT3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 4'd9, 32'h8000_0000, acc);
        issue(FUNCT3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 4'd10, 32'h0,        acc);
        repeat (2) @(posedge clk); #1;

        // Rollback ten cycles into a divide: only the later MUL returns.
        issue(FUNCT3_DIV, 32'd1000, 32'd3, 4'd11, 32'd333, acc);
        repeat (9) @(posedge clk);
        #1 rollback = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        #1 rollback = 1'b0;
        funct3 = FUNCT3_DIV;
        @(negedge clk);
        check("ready_after_rb", 64'(md_ready), 64'd1);
        @(posedge clk); #1;
        issue(FUNCT3_MUL, 32'd2, 32'd3, 4'd12, 32'd6, acc);

        // rdy low 5 cycles mid-divide shifts completion by exactly 5.
        issue(FUNCT3_DIVU, 32'd100, 32'd7, 4'd13, 32'd14, acc);
        repeat (8) @(posedge clk);
        #1 rdy = 1'b0;
        foreach (sb[i]) sb[i].due += 5;
        repeat (5) @(posedge clk);
        #1 rdy = 1'b1;
        repeat (40) @(posedge clk); #1;

        // DIV offered while a MUL is in flight waits for the pipe to drain.
        issue(FUNCT3_MUL, 32'd3, 32'd4, 4'd14, 32'd12, acc);
        md_en = 1'b1; funct3 = FUNCT3_DIV;
        @(negedge clk);
        check("div_blocked_by_mul", 64'(md_ready), 64'd0);
        issue(FUNCT3_DIV, 32'd100, 32'd7, 4'd15, 32'd14, acc2);
        check("div_wait_mul", 64'(acc2), 64'(acc + 3));

        // Mixed random traffic against the reference model.
        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 4 == 1) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i == 6) b = 32'd0;
            issue(f, a, b, 4'(i), model(f, a, b), acc);
        end

        for (int w = 0; w < 200 && sb.size() != 0; w++) @(posedge clk);
        @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
